// File: rtl/regfile_access_ctrl_if.sv
// Bundle between the register-file access controller, its two requesters
// (operand fetch and writeback) and the 32x32 register file itself.
// The controller connects through the slave modport; the requester/regfile
// side (or a testbench standing in for it) uses the master modport.
interface regfile_access_ctrl_if;
    // Operand read channel
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_rs1;
    logic [4:0]  rd_rs2;

    // Operand response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rs1_value;
    logic [31:0] rsp_rs2_value;

    // Writeback channel
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;

    // Register file side
    logic        rf_req_r;
    logic        rf_req_w;
    logic        rf_rs_read_n;
    logic        rf_rd_write_n;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_value;
    logic [31:0] rf_rs1_value;
    logic [31:0] rf_rs2_value;

    modport slave (
        input  rd_valid, rd_rs1, rd_rs2,
        input  rsp_ready,
        input  wb_valid, wb_rd, wb_value,
        input  rf_rs1_value, rf_rs2_value,
        output rd_ready,
        output rsp_valid, rsp_rs1_value, rsp_rs2_value,
        output wb_ready,
        output rf_req_r, rf_req_w, rf_rs_read_n, rf_rd_write_n,
        output rf_rs1, rf_rs2, rf_rd, rf_rd_value
    );

    modport master (
        output rd_valid, rd_rs1, rd_rs2,
        output rsp_ready,
        output wb_valid, wb_rd, wb_value,
        output rf_rs1_value, rf_rs2_value,
        input  rd_ready,
        input  rsp_valid, rsp_rs1_value, rsp_rs2_value,
        input  wb_ready,
        input  rf_req_r, rf_req_w, rf_rs_read_n, rf_rd_write_n,
        input  rf_rs1, rf_rs2, rf_rd, rf_rd_value
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Sequencer/arbiter in front of the 32x32 register file.
// Turns the read and writeback valid/ready handshakes into setup-stable,
// clock-aligned strobes with active-low enables, keeps x0 reading as zero
// and drops x0 writes, and limits how long writes can starve a pending read.
module regfile_access_ctrl #(
    parameter int STROBE_CYCLES = 1,
    parameter int MAX_WR_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        RD_SETUP,
        RD_STROBE,
        RD_CAPTURE,
        RD_RSP
    } state_t;

    // Strobe down-counter reload: the strobe stays high for the cycle in which
    // the counter is loaded plus one cycle per remaining count.
    localparam logic [3:0] StrobeLast = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] MaxBurst   = 4'(MAX_WR_BURST);

    state_t      state_q;
    logic [3:0]  strobeCnt_q;
    logic [3:0]  burstCnt_q;
    logic [3:0]  burstCnt_d;

    logic        reqR_q;
    logic        reqW_q;
    logic        readN_q;
    logic        writeN_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] rdValue_q;

    logic        rspValid_q;
    logic [31:0] rspRs1_q;
    logic [31:0] rspRs2_q;

    logic        isIdle;
    logic        burstFull;
    logic        wbReady;
    logic        rdReady;
    logic        wrGrant;
    logic        rdGrant;

    // Arbitration: only IDLE hands out ready, and only to the channel that
    // would win. A write wins a tie unless it has already used up its burst
    // allowance against a waiting read. Ready does not depend on the
    // channel's own valid, so with nothing pending both readies are offered.
    always_comb begin
        isIdle    = (state_q == IDLE);
        burstFull = (burstCnt_q == MaxBurst);
        wbReady   = isIdle && (!bus.rd_valid || !burstFull);
        rdReady   = isIdle && (!bus.wb_valid ||  burstFull);
        wrGrant   = bus.wb_valid && wbReady;
        rdGrant   = bus.rd_valid && rdReady;
    end

    // Burst accounting: count writes granted while a read is waiting,
    // saturating at the allowance; a granted read or an IDLE cycle with no
    // read waiting clears the count.
    always_comb begin
        burstCnt_d = burstCnt_q;
        if (isIdle) begin
            if (!bus.rd_valid || rdGrant) begin
                burstCnt_d = 4'd0;
            end else if (wrGrant && !burstFull) begin
                burstCnt_d = burstCnt_q + 4'd1;
            end
        end
    end

    // Main sequencer: every regfile-facing signal and the response are
    // registered here, so strobes and enables change only on clock edges and
    // an asynchronous reset pulls them to their idle levels immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            strobeCnt_q <= 4'd0;
            burstCnt_q  <= 4'd0;
            reqR_q      <= 1'b0;
            reqW_q      <= 1'b0;
            readN_q     <= 1'b1;
            writeN_q    <= 1'b1;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            rdValue_q   <= 32'd0;
            rspValid_q  <= 1'b0;
            rspRs1_q    <= 32'd0;
            rspRs2_q    <= 32'd0;
        end else begin
            burstCnt_q <= burstCnt_d;
            case (state_q)
                IDLE: begin
                    if (wrGrant) begin
                        // A write to x0 is consumed here without touching
                        // the regfile, so the channel is busy for one cycle.
                        if (bus.wb_rd != 5'd0) begin
                            rd_q      <= bus.wb_rd;
                            rdValue_q <= bus.wb_value;
                            writeN_q  <= 1'b0;
                            state_q   <= WR_SETUP;
                        end
                    end else if (rdGrant) begin
                        rs1_q   <= bus.rd_rs1;
                        rs2_q   <= bus.rd_rs2;
                        readN_q <= 1'b0;
                        state_q <= RD_SETUP;
                    end
                end

                WR_SETUP: begin
                    reqW_q      <= 1'b1;
                    strobeCnt_q <= StrobeLast;
                    state_q     <= WR_STROBE;
                end

                WR_STROBE: begin
                    if (strobeCnt_q == 4'd0) begin
                        reqW_q   <= 1'b0;
                        writeN_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        strobeCnt_q <= strobeCnt_q - 4'd1;
                    end
                end

                RD_SETUP: begin
                    reqR_q      <= 1'b1;
                    strobeCnt_q <= StrobeLast;
                    state_q     <= RD_STROBE;
                end

                RD_STROBE: begin
                    if (strobeCnt_q == 4'd0) begin
                        reqR_q  <= 1'b0;
                        state_q <= RD_CAPTURE;
                    end else begin
                        strobeCnt_q <= strobeCnt_q - 4'd1;
                    end
                end

                RD_CAPTURE: begin
                    // x0 always reads as zero whatever the array returns.
                    rspRs1_q   <= (rs1_q == 5'd0) ? 32'd0 : bus.rf_rs1_value;
                    rspRs2_q   <= (rs2_q == 5'd0) ? 32'd0 : bus.rf_rs2_value;
                    readN_q    <= 1'b1;
                    rspValid_q <= 1'b1;
                    state_q    <= RD_RSP;
                end

                RD_RSP: begin
                    if (bus.rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    // Unreachable encoding: park everything at idle levels.
                    reqR_q     <= 1'b0;
                    reqW_q     <= 1'b0;
                    readN_q    <= 1'b1;
                    writeN_q   <= 1'b1;
                    rspValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_ready      = rdReady;
    assign bus.wb_ready      = wbReady;
    assign bus.rsp_valid     = rspValid_q;
    assign bus.rsp_rs1_value = rspRs1_q;
    assign bus.rsp_rs2_value = rspRs2_q;
    assign bus.rf_req_r      = reqR_q;
    assign bus.rf_req_w      = reqW_q;
    assign bus.rf_rs_read_n  = readN_q;
    assign bus.rf_rd_write_n = writeN_q;
    assign bus.rf_rs1        = rs1_q;
    assign bus.rf_rs2        = rs2_q;
    assign bus.rf_rd         = rd_q;
    assign bus.rf_rd_value   = rdValue_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl. Two instances share the same stimulus:
// dutA uses the default strobe width, dutB a 3-cycle strobe. Each has its own
// behavioural register file. 'sel' chooses which instance is observed.
module tb_regfile_access_ctrl;

    localparam int WaitLimit = 40;

    logic clk;
    logic rst_n;
    bit   sel;

    logic        rdValid;
    logic [4:0]  rdRs1;
    logic [4:0]  rdRs2;
    logic        rspReady;
    logic        wbValid;
    logic [4:0]  wbRd;
    logic [31:0] wbValue;

    logic [31:0] memA [32];
    logic [31:0] memB [32];
    logic [31:0] rfA1, rfA2, rfB1, rfB2;

    int checks;
    int failures;
    bit grantLog [$];

    regfile_access_ctrl_if ifA ();
    regfile_access_ctrl_if ifB ();

    regfile_access_ctrl #(.STROBE_CYCLES(1), .MAX_WR_BURST(4)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA.slave)
    );

    regfile_access_ctrl #(.STROBE_CYCLES(3), .MAX_WR_BURST(4)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB.slave)
    );

    assign ifA.rd_valid     = rdValid;
    assign ifA.rd_rs1       = rdRs1;
    assign ifA.rd_rs2       = rdRs2;
    assign ifA.rsp_ready    = rspReady;
    assign ifA.wb_valid     = wbValid;
    assign ifA.wb_rd        = wbRd;
    assign ifA.wb_value     = wbValue;
    assign ifA.rf_rs1_value = rfA1;
    assign ifA.rf_rs2_value = rfA2;

    assign ifB.rd_valid     = rdValid;
    assign ifB.rd_rs1       = rdRs1;
    assign ifB.rd_rs2       = rdRs2;
    assign ifB.rsp_ready    = rspReady;
    assign ifB.wb_valid     = wbValid;
    assign ifB.wb_rd        = wbRd;
    assign ifB.wb_value     = wbValue;
    assign ifB.rf_rs1_value = rfB1;
    assign ifB.rf_rs2_value = rfB2;

    // Observed-instance view
    logic        obsRdReady, obsWbReady, obsRspValid, obsReqR, obsReqW;
    logic        obsReadN, obsWriteN;
    logic [4:0]  obsRfRd;
    logic [31:0] obsRs1, obsRs2;

    always_comb begin
        obsRdReady  = sel ? ifB.rd_ready      : ifA.rd_ready;
        obsWbReady  = sel ? ifB.wb_ready      : ifA.wb_ready;
        obsRspValid = sel ? ifB.rsp_valid     : ifA.rsp_valid;
        obsReqR     = sel ? ifB.rf_req_r      : ifA.rf_req_r;
        obsReqW     = sel ? ifB.rf_req_w      : ifA.rf_req_w;
        obsReadN    = sel ? ifB.rf_rs_read_n  : ifA.rf_rs_read_n;
        obsWriteN   = sel ? ifB.rf_rd_write_n : ifA.rf_rd_write_n;
        obsRfRd     = sel ? ifB.rf_rd         : ifA.rf_rd;
        obsRs1      = sel ? ifB.rsp_rs1_value : ifA.rsp_rs1_value;
        obsRs2      = sel ? ifB.rsp_rs2_value : ifA.rsp_rs2_value;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register files: sample on the rising edge of the strobe.
    always @(posedge ifA.rf_req_w) if (!ifA.rf_rd_write_n) memA[ifA.rf_rd] <= ifA.rf_rd_value;
    always @(posedge ifB.rf_req_w) if (!ifB.rf_rd_write_n) memB[ifB.rf_rd] <= ifB.rf_rd_value;
    always @(posedge ifA.rf_req_r) if (!ifA.rf_rs_read_n) begin
        rfA1 <= memA[ifA.rf_rs1];
        rfA2 <= memA[ifA.rf_rs2];
    end
    always @(posedge ifB.rf_req_r) if (!ifB.rf_rs_read_n) begin
        rfB1 <= memB[ifB.rf_rs1];
        rfB2 <= memB[ifB.rf_rs2];
    end

    // Grant monitor: inputs are stable from negedge+0 until the next posedge,
    // so a handshake seen here is the one accepted on the coming edge.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (wbValid && obsWbReady) grantLog.push_back(1'b1);
            if (rdValid && obsRdReady) grantLog.push_back(1'b0);
        end
    end

    initial begin
        #500000;
        $display("[TB] watchdog expired, stopping");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic applyReset();
        rst_n    = 1'b0;
        rdValid  = 1'b0;
        wbValid  = 1'b0;
        rspReady = 1'b0;
        rdRs1    = 5'd0;
        rdRs2    = 5'd0;
        wbRd     = 5'd0;
        wbValue  = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic doWrite(input logic [4:0] rd, input logic [31:0] val,
                           input int expStrobes, output int occ);
        int n;
        int strobes;
        strobes = 0;
        occ     = 0;
        @(negedge clk);
        wbValid = 1'b1;
        wbRd    = rd;
        wbValue = val;
        #1;
        n = 0;
        while (!obsWbReady && n < WaitLimit) begin
            @(negedge clk); #1; n++;
        end
        checkOutput($sformatf("wb accept x%0d", rd), 32'(obsWbReady), 32'd1);
        if (!obsWbReady) begin
            wbValid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        wbValid = 1'b0;
        #1;
        n = 0;
        while (!(obsWbReady || obsRdReady) && n < WaitLimit) begin
            if (obsReqW) strobes++;
            occ++;
            @(negedge clk); #1; n++;
        end
        occ++;
        checkOutput($sformatf("wr x%0d back idle", rd), 32'(obsWbReady || obsRdReady), 32'd1);
        checkOutput($sformatf("wr x%0d strobe cycles", rd), 32'(strobes), 32'(expStrobes));
    endtask

    task automatic doRead(input logic [4:0] a1, input logic [4:0] a2,
                          input logic [31:0] exp1, input logic [31:0] exp2,
                          input int hold, input int expLat, input int expStrobes);
        int n;
        int lat;
        int strobes;
        strobes = 0;
        @(negedge clk);
        rdValid  = 1'b1;
        rdRs1    = a1;
        rdRs2    = a2;
        rspReady = 1'b0;
        #1;
        n = 0;
        while (!obsRdReady && n < WaitLimit) begin
            @(negedge clk); #1; n++;
        end
        checkOutput($sformatf("rd accept %0d/%0d", a1, a2), 32'(obsRdReady), 32'd1);
        if (!obsRdReady) begin
            rdValid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        rdValid = 1'b0;
        #1;
        lat = 1;
        n   = 0;
        while (!obsRspValid && n < WaitLimit) begin
            if (obsReqR) strobes++;
            @(negedge clk); #1; lat++; n++;
        end
        checkOutput($sformatf("rd %0d/%0d rsp_valid", a1, a2), 32'(obsRspValid), 32'd1);
        if (!obsRspValid) return;
        checkOutput($sformatf("rd %0d/%0d latency", a1, a2), 32'(lat), 32'(expLat));
        checkOutput($sformatf("rd %0d/%0d strobe cycles", a1, a2), 32'(strobes), 32'(expStrobes));
        checkOutput($sformatf("rd %0d/%0d rs1 value", a1, a2), obsRs1, exp1);
        checkOutput($sformatf("rd %0d/%0d rs2 value", a1, a2), obsRs2, exp2);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            checkOutput($sformatf("hold%0d rsp_valid", h), 32'(obsRspValid), 32'd1);
            checkOutput($sformatf("hold%0d rs1", h), obsRs1, exp1);
            checkOutput($sformatf("hold%0d rs2", h), obsRs2, exp2);
            checkOutput($sformatf("hold%0d readies", h), 32'({obsRdReady, obsWbReady}), 32'd0);
        end
        rspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rspReady = 1'b0;
        #1;
        checkOutput($sformatf("rd %0d/%0d rsp drop", a1, a2), 32'(obsRspValid), 32'd0);
        checkOutput($sformatf("rd %0d/%0d back idle", a1, a2), 32'(obsRdReady || obsWbReady), 32'd1);
    endtask

    task automatic checkGrants(input string name, input int expN, input logic [7:0] expCode);
        logic [7:0] code;
        code = 8'd0;
        foreach (grantLog[i]) code = {code[6:0], grantLog[i]};
        checkOutput(name, (32'(grantLog.size()) << 8) | 32'(code), (32'(expN) << 8) | 32'(expCode));
    endtask

    typedef struct {
        bit          isWr;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] data;
        logic [31:0] exp1;
        logic [31:0] exp2;
        int          expStrobes;
    } vec_t;

    task automatic applyStimulus(input vec_t v);
        int occ;
        if (v.isWr) begin
            doWrite(v.a1, v.data, v.expStrobes, occ);
            if (v.a1 == 5'd0) checkOutput("x0 write occupancy", 32'(occ), 32'd1);
        end else begin
            doRead(v.a1, v.a2, v.exp1, v.exp2, 0, 4, v.expStrobes);
        end
    endtask

    initial begin
        vec_t vecs [10];
        int   occ;

        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        for (int i = 0; i < 32; i++) begin
            memA[i] = 32'h1000_0000 + 32'(i);
            memB[i] = 32'h1000_0000 + 32'(i);
        end
        memA[0] = 32'hBAD0_0000;
        memB[0] = 32'hBAD0_0000;
        rfA1 = 32'd0; rfA2 = 32'd0; rfB1 = 32'd0; rfB2 = 32'd0;

        //            isWr  a1     a2     data          exp1          exp2          strobes
        vecs[0] = '{1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        1};
        vecs[1] = '{1'b0, 5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        1};
        vecs[2] = '{1'b1, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        32'h0,        0};
        vecs[3] = '{1'b0, 5'd0,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF, 1};
        vecs[4] = '{1'b1, 5'd31, 5'd0,  32'hA5A55A5A, 32'h0,        32'h0,        1};
        vecs[5] = '{1'b1, 5'd1,  5'd0,  32'h00000001, 32'h0,        32'h0,        1};
        vecs[6] = '{1'b0, 5'd31, 5'd1,  32'h0,        32'hA5A55A5A, 32'h00000001, 1};
        vecs[7] = '{1'b0, 5'd2,  5'd3,  32'h0,        32'h10000002, 32'h10000003, 1};
        vecs[8] = '{1'b1, 5'd5,  5'd0,  32'hCAFEF00D, 32'h0,        32'h0,        1};
        vecs[9] = '{1'b0, 5'd5,  5'd31, 32'h0,        32'hCAFEF00D, 32'hA5A55A5A, 1};

        // Reset state
        applyReset();
        checkOutput("reset rf_req_r",      32'(obsReqR),     32'd0);
        checkOutput("reset rf_req_w",      32'(obsReqW),     32'd0);
        checkOutput("reset rf_rs_read_n",  32'(obsReadN),    32'd1);
        checkOutput("reset rf_rd_write_n", 32'(obsWriteN),   32'd1);
        checkOutput("reset rsp_valid",     32'(obsRspValid), 32'd0);
        checkOutput("reset rsp_rs1",       obsRs1,           32'd0);
        checkOutput("reset rf_rd",         32'(obsRfRd),     32'd0);
        checkOutput("reset readies",       32'({obsRdReady, obsWbReady}), 32'd3);

        // Directed vectors on the default-strobe instance
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Simultaneous write and read to the same register: write goes first
        grantLog.delete();
        fork
            doWrite(5'd7, 32'h12345678, 1, occ);
            doRead(5'd7, 5'd0, 32'h12345678, 32'd0, 0, 4, 1);
        join
        checkGrants("same-cycle grant order", 2, 8'b10);

        // Read held against a stream of six writes: four writes, the read, two writes
        grantLog.delete();
        fork
            begin
                int n;
                @(negedge clk);
                for (int j = 0; j < 6; j++) begin
                    wbValid = 1'b1;
                    wbRd    = 5'(10 + j);
                    wbValue = 32'hB000_0000 + 32'(j);
                    #1;
                    n = 0;
                    while (!obsWbReady && n < WaitLimit) begin
                        @(negedge clk); #1; n++;
                    end
                    checkOutput($sformatf("burst write %0d ready", j), 32'(obsWbReady), 32'd1);
                    @(posedge clk);
                    @(negedge clk);
                end
                wbValid = 1'b0;
            end
            doRead(5'd13, 5'd14, 32'hB000_0003, 32'h1000_000E, 0, 4, 1);
        join
        repeat (6) @(negedge clk);
        checkGrants("burst grant order", 7, 8'b1111011);
        doRead(5'd14, 5'd15, 32'hB000_0004, 32'hB000_0005, 0, 4, 1);

        // Three-cycle strobe instance: strobe width, latency, held response
        sel = 1'b1;
        applyReset();
        doWrite(5'd9, 32'h0BAD_CAFE, 3, occ);
        doRead(5'd9, 5'd0, 32'h0BAD_CAFE, 32'd0, 5, 6, 3);

        // Reset asserted while the read strobe is high
        applyReset();
        @(negedge clk);
        rdValid = 1'b1;
        rdRs1   = 5'd9;
        rdRs2   = 5'd9;
        #1;
        checkOutput("rst-test rd_ready", 32'(obsRdReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rdValid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst-test strobe high", 32'(obsReqR), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst-test rf_req_r drop", 32'(obsReqR),     32'd0);
        checkOutput("rst-test rsp_valid",     32'(obsRspValid), 32'd0);
        checkOutput("rst-test read_n",        32'(obsReadN),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst-test readies", 32'({obsRdReady, obsWbReady}), 32'd3);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("rst-test no strobe", 32'({obsReqR, obsReqW, obsRspValid}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
